// File: rtl/ysyx_22040237_mdu_pkg.sv
// Shared encodings for the iterative RV64M multiply/divide unit.
package ysyx_22040237_mdu_pkg;

    localparam int unsigned MDU_WOP_N = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } mdu_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } mdu_state_e;

endpackage

// File: rtl/ysyx_22040237_mdu_div_step.sv
// One restoring-divide iteration: shift in the next dividend bit and
// subtract the divisor when it fits.
module ysyx_22040237_mdu_div_step #(
    parameter int unsigned XLEN = 64
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] dvs_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    always_comb begin
        shifted = {rem_i, quo_i[XLEN-1]};
        diff    = shifted - {1'b0, dvs_i};
        if (diff[XLEN]) begin
            rem_o = shifted[XLEN-1:0];
            quo_o = {quo_i[XLEN-2:0], 1'b0};
        end else begin
            rem_o = diff[XLEN-1:0];
            quo_o = {quo_i[XLEN-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/ysyx_22040237_mdu.sv
// Multi-cycle RV64M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on sign magnitudes, with valid/ready on both sides.
module ysyx_22040237_mdu
    import ysyx_22040237_mdu_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [2:0]      op_i,
    input  logic            wop_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [4:0]      rd_idx_i,
    input  logic            flush_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] res_o,
    output logic [4:0]      rd_idx_o,
    output logic            busy_o
);
    localparam int unsigned CW = $clog2(XLEN + 1);

    mdu_state_e        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    mdu_op_e           op_q, op_d;
    logic              wop_q, wop_d;
    logic [4:0]        rd_q, rd_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   dvs_q, dvs_d;
    logic              qneg_q, qneg_d;
    logic              rneg_q, rneg_d;
    logic [XLEN-1:0]   res_q, res_d;

    logic              div_op, mulw, sgn1, sgn2, neg1, neg2, div_zero, div_ovf;
    logic [XLEN-1:0]   a_ext, b_ext, a_mag, b_mag, most_neg;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_sel, fix_res;
    logic [XLEN-1:0]   step_rem, step_quo;

    ysyx_22040237_mdu_div_step #(.XLEN(XLEN)) u_div_step (
        .rem_i (acc_q[2*XLEN-1:XLEN]),
        .quo_i (acc_q[XLEN-1:0]),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    // Operand preparation for the offered operation.
    always_comb begin
        div_op = op_i[2];
        mulw   = wop_i && !div_op;
        if (!wop_i) begin
            a_ext = rs1_i;
            b_ext = rs2_i;
        end else if (div_op && !op_i[0]) begin
            a_ext = XLEN'($signed(rs1_i[31:0]));
            b_ext = XLEN'($signed(rs2_i[31:0]));
        end else begin
            a_ext = XLEN'(rs1_i[31:0]);
            b_ext = XLEN'(rs2_i[31:0]);
        end
        sgn1     = div_op ? !op_i[0] : (!mulw && !(op_i[1] && op_i[0]));
        sgn2     = div_op ? !op_i[0] : (!mulw && !op_i[1]);
        neg1     = sgn1 && a_ext[XLEN-1];
        neg2     = sgn2 && b_ext[XLEN-1];
        a_mag    = neg1 ? -a_ext : a_ext;
        b_mag    = neg2 ? -b_ext : b_ext;
        most_neg = wop_i ? XLEN'($signed(32'h8000_0000)) : (XLEN'(1) << (XLEN - 1));
        div_zero = (b_ext == '0);
        div_ovf  = sgn1 && (a_ext == most_neg) && (b_ext == '1);
    end

    // Sign correction and result selection used by FIX.
    always_comb begin
        prod    = qneg_q ? -acc_q : acc_q;
        quo_fix = qneg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        if (op_q[2]) begin
            fix_sel = op_q[1] ? rem_fix : quo_fix;
        end else if (wop_q) begin
            // after 32 shifts the low product word sits above the unshifted multiplier bits
            fix_sel = XLEN'(acc_q[XLEN-MDU_WOP_N +: MDU_WOP_N]);
        end else if (op_q == OP_MUL) begin
            fix_sel = prod[XLEN-1:0];
        end else begin
            fix_sel = prod[2*XLEN-1:XLEN];
        end
        fix_res = wop_q ? XLEN'($signed(fix_sel[31:0])) : fix_sel;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        wop_d   = wop_q;
        rd_d    = rd_q;
        acc_d   = acc_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        res_d   = res_q;
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
        if (flush_i) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (in_valid_i && in_ready_o) begin
                        op_d   = mulw ? OP_MUL : mdu_op_e'(op_i);
                        wop_d  = wop_i;
                        rd_d   = rd_idx_i;
                        qneg_d = neg1 ^ neg2;
                        rneg_d = neg1;
                        dvs_d  = div_op ? b_mag : a_mag;
                        cnt_d  = wop_i ? CW'(MDU_WOP_N) : CW'(XLEN);
                        if (div_op && (div_zero || div_ovf)) begin
                            // preload quotient/remainder so FIX only selects and W-extends them
                            qneg_d  = 1'b0;
                            rneg_d  = 1'b0;
                            cnt_d   = '0;
                            acc_d   = div_zero ? {a_ext, {XLEN{1'b1}}} : {{XLEN{1'b0}}, a_ext};
                            state_d = S_FIX;
                        end else if (div_op) begin
                            acc_d   = {{XLEN{1'b0}},
                                       wop_i ? (a_mag << (XLEN - MDU_WOP_N)) : a_mag};
                            state_d = S_DIV;
                        end else begin
                            acc_d   = {{XLEN{1'b0}}, b_mag};
                            state_d = S_MUL;
                        end
                    end
                end
                S_MUL: begin
                    acc_d = {mul_sum, acc_q[XLEN-1:1]};
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_d = S_FIX;
                end
                S_DIV: begin
                    acc_d = {step_rem, step_quo};
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_d = S_FIX;
                end
                S_FIX: begin
                    res_d   = fix_res;
                    state_d = S_DONE;
                end
                S_DONE: begin
                    if (out_ready_i) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_MUL;
            wop_q   <= 1'b0;
            rd_q    <= '0;
            acc_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            wop_q   <= wop_d;
            rd_q    <= rd_d;
            acc_q   <= acc_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            res_q   <= res_d;
        end
    end

    assign in_ready_o  = (state_q == S_IDLE) && !rst;
    assign out_valid_o = (state_q == S_DONE);
    assign busy_o      = (state_q != S_IDLE);
    assign res_o       = res_q;
    assign rd_idx_o    = rd_q;

endmodule
